data_reader: RTL and testbench

DATA_READER -- requirements
Module: data_reader

---
 rtl/data_reader.sv | 116 +++++++++++
 tb/tb_data_reader.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_reader.sv
// Memory-to-UART dump engine: streams bytes 0..LAST_ADDR from a 1-cycle-latency memory.
// Optional READER_HEADER_EN prepends 16 SYNC_BYTE header bytes to every dump.
module data_reader #(
  parameter logic [15:0] LAST_ADDR = 16'd65535,
  parameter logic [7:0]  SYNC_BYTE = 8'hAA
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  Din,
  input  logic        Tx_done,
  output logic [15:0] Addr,
  output logic        Ren,
  output logic [7:0]  Dout,
  output logic        Tx_start,
  output logic        fin
);

  typedef enum logic [2:0] {IDLE, HEADER, FETCH, SEND, WAIT_TX, DONE} state_t;

  state_t state, state_nxt;

`ifdef READER_HEADER_EN
  logic [3:0] hdr_cnt;
  logic       hdr_busy;   // a header byte is on the wire, waiting for Tx_done
`else
  wire unused_sync = ^SYNC_BYTE;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (start) begin
`ifdef READER_HEADER_EN
          state_nxt = HEADER;
`else
          state_nxt = FETCH;
`endif
        end
      end
`ifdef READER_HEADER_EN
      HEADER:  if (hdr_busy && Tx_done && hdr_cnt == 4'hF) state_nxt = FETCH;
`endif
      FETCH:   state_nxt = SEND;
      SEND:    state_nxt = WAIT_TX;
      WAIT_TX: if (Tx_done) state_nxt = (Addr == LAST_ADDR) ? DONE : FETCH;
      default: state_nxt = state;
    endcase
  end

  // Datapath registers; Tx_start is a registered single-cycle strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Addr     <= '0;
      Ren      <= 1'b0;
      Dout     <= '0;
      Tx_start <= 1'b0;
      fin      <= 1'b0;
`ifdef READER_HEADER_EN
      hdr_cnt  <= '0;
      hdr_busy <= 1'b0;
`endif
    end else begin
      Tx_start <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            Addr <= '0;
            Ren  <= 1'b1;
            fin  <= 1'b0;
`ifdef READER_HEADER_EN
            hdr_cnt  <= '0;
            hdr_busy <= 1'b0;
`endif
          end
        end
`ifdef READER_HEADER_EN
        HEADER: begin
          if (!hdr_busy) begin
            Dout     <= SYNC_BYTE;
            Tx_start <= 1'b1;
            hdr_busy <= 1'b1;
          end else if (Tx_done) begin
            hdr_busy <= 1'b0;
            hdr_cnt  <= hdr_cnt + 4'd1;
          end
        end
`endif
        SEND: begin
          Dout     <= Din;
          Tx_start <= 1'b1;
        end
        WAIT_TX: begin
          if (Tx_done) begin
            // Compare before incrementing so Addr never wraps past LAST_ADDR.
            if (Addr == LAST_ADDR) begin
              Addr <= '0;
              Ren  <= 1'b0;
              fin  <= 1'b1;
            end else begin
              Addr <= Addr + 16'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_data_reader.sv
// Randomized bench for data_reader: memory model, random-latency UART responder,
// and an expected byte/timing stream derived from the dump rules.
module tb_data_reader;

  localparam logic [15:0] LAST = 16'd7;
  localparam logic [7:0]  SYNC = 8'hAA;
`ifdef READER_HEADER_EN
  localparam int NHDR = 16;
`else
  localparam int NHDR = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  Din = '0;
  logic        Tx_done;
  logic [15:0] Addr;
  logic        Ren;
  logic [7:0]  Dout;
  logic        Tx_start;
  logic        fin;

  logic resp_done = 1'b0, spur_done = 1'b0, resp_en = 1'b0;
  assign Tx_done = resp_done | spur_done;

  data_reader #(.LAST_ADDR(LAST), .SYNC_BYTE(SYNC)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .Din(Din), .Tx_done(Tx_done),
    .Addr(Addr), .Ren(Ren), .Dout(Dout), .Tx_start(Tx_start), .fin(fin)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int cyc = 0;
  int s_cyc;
  logic oob = 1'b0;
  logic [7:0] mem [0:7];

  typedef struct { int c; logic [15:0] addr; logic [7:0] data; logic fin; } tx_t;
  tx_t tx_q[$];
  int  done_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous memory: data appears one clock after Addr/Ren.
  always @(posedge clk) if (Ren) Din <= mem[Addr[2:0]];

  always @(negedge clk) begin
    if (Tx_start) tx_q.push_back('{cyc, Addr, Dout, fin});
    if (Addr > LAST) oob = 1'b1;
  end

  // UART responder: Tx_done pulse a random 1..12 cycles after each Tx_start.
  initial begin
    forever begin
      @(negedge clk);
      if (Tx_start && resp_en) begin
        repeat ($urandom_range(1, 12)) @(negedge clk);
        resp_done = 1'b1;
        done_q.push_back(cyc + 1);
        @(negedge clk);
        resp_done = 1'b0;
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    s_cyc = cyc + 1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({Addr, Ren, Dout, Tx_start, fin} !== 27'd0) begin
      errors++;
      $display("FAIL reset_outputs got Addr=%0d Ren=%b Dout=%0d Tx_start=%b fin=%b want all 0",
               Addr, Ren, Dout, Tx_start, fin);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_spurious_done(string nm);
    logic [15:0] a0; logic r0, f0;
    a0 = Addr; r0 = Ren; f0 = fin;
    tx_q.delete();
    @(negedge clk); spur_done = 1'b1;
    @(negedge clk); spur_done = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (Addr !== a0 || Ren !== r0 || fin !== f0 || tx_q.size() != 0) begin
      errors++;
      $display("FAIL %s got Addr=%0d Ren=%b fin=%b tx=%0d want Addr=%0d Ren=%b fin=%b tx=0",
               nm, Addr, Ren, fin, tx_q.size(), a0, r0, f0);
    end
  endtask

  task automatic test_dump(string nm);
    tx_t exp[$];
    int t, f, gap;
    for (int i = 0; i < 8; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < NHDR; i++) exp.push_back('{0, 16'd0, SYNC, 1'b0});
    for (int i = 0; i <= int'(LAST); i++) exp.push_back('{0, 16'(i), mem[i], 1'b0});
    tx_q.delete(); done_q.delete(); oob = 1'b0;
    resp_en = 1'b1;
    pulse_start();
    t = 0;
    while (!fin && t < 3000) begin @(negedge clk); t++; end
    f = cyc;
    checks++;
    if (!fin) begin
      errors++;
      $display("FAIL %s_timeout fin=%b after %0d cycles want 1", nm, fin, t);
    end
    checks++;
    if (tx_q.size() != exp.size()) begin
      errors++;
      $display("FAIL %s_count got %0d bytes want %0d", nm, tx_q.size(), exp.size());
    end
    for (int i = 0; i < tx_q.size() && i < exp.size(); i++) begin
      checks++;
      if (tx_q[i].data !== exp[i].data || tx_q[i].addr !== exp[i].addr || tx_q[i].fin !== 1'b0) begin
        errors++;
        $display("FAIL %s_byte%0d got data=%h addr=%0d fin=%b want data=%h addr=%0d fin=0",
                 nm, i, tx_q[i].data, tx_q[i].addr, tx_q[i].fin, exp[i].data, exp[i].addr);
      end
      if (i == 0) t = s_cyc + ((NHDR > 0) ? 1 : 2);
      else if (i - 1 < done_q.size()) begin
        gap = (i < NHDR) ? 1 : 2;
        t = done_q[i-1] + gap;
      end else t = -1;
      checks++;
      if (tx_q[i].c != t) begin
        errors++;
        $display("FAIL %s_time%0d got cycle %0d want %0d", nm, i, tx_q[i].c, t);
      end
    end
    checks++;
    if (done_q.size() == 0 || f != done_q[done_q.size()-1]) begin
      errors++;
      $display("FAIL %s_fin_time got cycle %0d want last Tx_done cycle", nm, f);
    end
    checks++;
    if (Addr !== 16'd0 || Ren !== 1'b0 || oob) begin
      errors++;
      $display("FAIL %s_end got Addr=%0d Ren=%b overrun=%b want Addr=0 Ren=0 overrun=0",
               nm, Addr, Ren, oob);
    end
    repeat (15) @(negedge clk);
  endtask

  task automatic test_ignore_start();
    int t = 0;
    resp_en = 1'b0;
    tx_q.delete();
    pulse_start();
    while (tx_q.size() == 0 && t < 100) begin @(negedge clk); t++; end
    checks++;
    if (tx_q.size() != 1) begin
      errors++;
      $display("FAIL ignore_first_tx got %0d Tx_start pulses want 1", tx_q.size());
    end
    repeat (2) @(negedge clk);
    pulse_start();
    repeat (8) @(negedge clk);
    checks++;
    if (tx_q.size() != 1 || Addr !== 16'd0 || Ren !== 1'b1 || fin !== 1'b0) begin
      errors++;
      $display("FAIL ignore_start got tx=%0d Addr=%0d Ren=%b fin=%b want tx=1 Addr=0 Ren=1 fin=0",
               tx_q.size(), Addr, Ren, fin);
    end
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int t = 0;
    resp_en = 1'b1;
    tx_q.delete();
    for (int i = 0; i < 8; i++) mem[i] = 8'($urandom);
    pulse_start();
    while (!(Tx_start && Addr == 16'd5) && t < 3000) begin @(negedge clk); t++; end
    resp_en = 1'b0;
    checks++;
    if (Addr !== 16'd5) begin
      errors++;
      $display("FAIL reset_mid_reach got Addr=%0d want 5", Addr);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({Addr, Ren, Dout, Tx_start, fin} !== 27'd0) begin
      errors++;
      $display("FAIL reset_mid_async got Addr=%0d Ren=%b Dout=%0d Tx_start=%b fin=%b want all 0",
               Addr, Ren, Dout, Tx_start, fin);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    tx_q.delete();
    repeat (20) @(negedge clk);
    checks++;
    if (tx_q.size() != 0 || Addr !== 16'd0 || Ren !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_quiet got tx=%0d Addr=%0d Ren=%b want tx=0 Addr=0 Ren=0",
               tx_q.size(), Addr, Ren);
    end
  endtask

  initial begin
    test_reset();
    test_spurious_done("spurious_idle");
    test_dump("dump_a");
    test_spurious_done("spurious_done_state");
    test_dump("dump_b");
    test_ignore_start();
    test_reset_mid();
    test_dump("dump_after_reset");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
